// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store constants and LSU state encoding.
// Used by the load/store unit and its extension helper.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] LSU_IDLE_CTRL = 3'b111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_SPLIT,
        LSU_RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        unique case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-result sign/zero extension by funct3.
// Shared by the native and byte-split load paths.
module lsu_extend
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        unique case (1'b1)
            funct3 == F3_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            funct3 == F3_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            funct3 == F3_LBU: ext = {24'b0, raw[7:0]};
            funct3 == F3_LHU: ext = {16'b0, raw[15:0]};
            default:          ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, registered memory controls,
// misaligned accesses optionally split into little-endian byte accesses.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter bit         SPLIT_EN  = 1'b1,
    parameter logic [2:0] IDLE_CTRL = LSU_IDLE_CTRL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [2:0]  mem_read_ctrl,
    output logic [2:0]  mem_write_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [2:0]  rd_ctrl_q, rd_ctrl_d;
    logic [2:0]  wr_ctrl_q, wr_ctrl_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]  last;
    logic [1:0]  nxt;
    logic [31:0] merged;
    logic [31:0] raw;
    logic [31:0] ext_data;
    logic        req_legal;
    logic        req_mis;

    lsu_extend u_ext (
        .funct3 (funct3_q),
        .raw    (raw),
        .ext    (ext_data)
    );

    always_comb begin
        last      = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
        nxt       = cnt_q + 2'd1;
        merged    = asm_q;
        merged[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
        raw       = (state_q == LSU_SPLIT) ? merged : mem_rdata;
        req_legal = f3_legal(req_is_store, req_funct3);
        req_mis   = misaligned(req_funct3, req_addr[1:0]);
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        rd_ctrl_d    = IDLE_CTRL;
        wr_ctrl_d    = IDLE_CTRL;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    cnt_d      = 2'd0;
                    asm_d      = '0;
                    if (!req_legal || (req_mis && !SPLIT_EN)) begin
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_mis) begin
                        state_d     = LSU_SPLIT;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = {24'b0, req_wdata[7:0]};
                        if (req_is_store) wr_ctrl_d = F3_SB;
                        else              rd_ctrl_d = F3_LBU;
                    end else begin
                        state_d     = LSU_ACCESS;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        if (req_is_store) wr_ctrl_d = req_funct3;
                        else              rd_ctrl_d = req_funct3;
                    end
                end
            end
            LSU_ACCESS: begin
                state_d      = LSU_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = is_store_q ? '0 : ext_data;
            end
            LSU_SPLIT: begin
                if (!is_store_q) asm_d = merged;
                if (cnt_q == last) begin
                    state_d      = LSU_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = is_store_q ? '0 : ext_data;
                end else begin
                    cnt_d       = nxt;
                    mem_addr_d  = addr_q + {30'b0, nxt};
                    mem_wdata_d = {24'b0, wdata_q[{nxt, 3'b000} +: 8]};
                    if (is_store_q) wr_ctrl_d = F3_SB;
                    else            rd_ctrl_d = F3_LBU;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 2'd0;
            asm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            rd_ctrl_q    <= IDLE_CTRL;
            wr_ctrl_q    <= IDLE_CTRL;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            rd_ctrl_q    <= rd_ctrl_d;
            wr_ctrl_q    <= wr_ctrl_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready      = (state_q == LSU_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_read_ctrl  = rd_ctrl_q;
    assign mem_write_ctrl = wr_ctrl_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic
// against a byte-array reference of the memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [2:0]  mem_read_ctrl, mem_write_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        ns_req_valid, ns_req_ready;
    logic        ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata;
    logic [2:0]  ns_rd_ctrl, ns_wr_ctrl;
    logic [31:0] ns_mem_addr, ns_mem_wdata;
    logic [31:0] ns_mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_EN(1'b1), .IDLE_CTRL(3'b111)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.SPLIT_EN(1'b0), .IDLE_CTRL(3'b111)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_is_store(1'b0), .req_funct3(3'b010),
        .req_addr(32'h0000_0002), .req_wdata(32'h0),
        .resp_valid(ns_resp_valid), .resp_err(ns_resp_err), .resp_rdata(ns_resp_rdata),
        .mem_read_ctrl(ns_rd_ctrl), .mem_write_ctrl(ns_wr_ctrl),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata)
    );

    assign ns_mem_rdata = 32'h0;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       fill;
    int         acc_cnt = 0;
    int         ns_acc_cnt = 0;
    wr_t        wr_log[$];
    int         n_chk = 0;
    int         n_pass = 0;

    function automatic logic [7:0] ba(input logic [31:0] a, input int i);
        logic [31:0] s;
        s = a + 32'(i);
        return s[7:0];
    endfunction

    // Simple byte-addressable memory seen by the DUT (aliased to 256 bytes)
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 5) & 255);
        end else begin
            case (mem_write_ctrl)
                3'b000: mem[ba(mem_addr, 0)] <= mem_wdata[7:0];
                3'b001: begin
                    mem[ba(mem_addr, 0)] <= mem_wdata[7:0];
                    mem[ba(mem_addr, 1)] <= mem_wdata[15:8];
                end
                3'b010: begin
                    mem[ba(mem_addr, 0)] <= mem_wdata[7:0];
                    mem[ba(mem_addr, 1)] <= mem_wdata[15:8];
                    mem[ba(mem_addr, 2)] <= mem_wdata[23:16];
                    mem[ba(mem_addr, 3)] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
        if (mem_read_ctrl != 3'b111 || mem_write_ctrl != 3'b111)
            acc_cnt <= acc_cnt + 1;
        if (mem_write_ctrl != 3'b111)
            wr_log.push_back('{c: mem_write_ctrl, a: mem_addr, d: mem_wdata});
        if (ns_rd_ctrl != 3'b111 || ns_wr_ctrl != 3'b111)
            ns_acc_cnt <= ns_acc_cnt + 1;
    end

    always_comb begin
        logic [31:0] w;
        w = {mem[ba(mem_addr, 3)], mem[ba(mem_addr, 2)],
             mem[ba(mem_addr, 1)], mem[ba(mem_addr, 0)]};
        case (mem_read_ctrl)
            3'b000:  mem_rdata = {{24{w[7]}}, w[7:0]};
            3'b001:  mem_rdata = {{16{w[15]}}, w[15:0]};
            3'b010:  mem_rdata = w;
            3'b100:  mem_rdata = {24'b0, w[7:0]};
            3'b101:  mem_rdata = {16'b0, w[15:0]};
            default: mem_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int n;
        n = acc_size(f3);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[ba(a, i)]) << (8 * i));
        if (f3 == 3'b000 && v >= 128)   v = v - 256;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
        logic        ill, mis;
        logic [31:0] exp_d;
        int          n, lat, acc0, exp_lat;
        n   = acc_size(f3);
        ill = st ? (f3 > 3'b010) : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        mis = !ill && (n > 1) && ((a % n) != 0);
        exp_lat = ill ? 0 : (mis ? n : 1);
        exp_d = (ill || st) ? 32'h0 : ref_load(f3, a);
        if (!ill && st)
            for (int i = 0; i < n; i++) ref_mem[ba(a, i)] = 8'(wd >> (8 * i));

        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        acc0 = acc_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_is_store = $urandom_range(0, 1) == 1;
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("resp_err", resp_err, ill);
        chk("resp_rdata", resp_rdata, exp_d);
        got = resp_rdata;
        @(negedge clk);
        chk("resp_pulse", resp_valid, 1'b0);
        chk("ready_back", req_ready, 1'b1);
        chk("mem_accesses", acc_cnt - acc0, ill ? 0 : exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int base, bad;
        rst = 1'b1; fill = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; ns_req_valid = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        fill = 1'b0;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_rd_ctrl", mem_read_ctrl, 3'b111);
        chk("rst_wr_ctrl", mem_write_ctrl, 3'b111);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        base = wr_log.size();
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r);
        chk("sw_nwrites", wr_log.size() - base, 1);
        if (wr_log.size() > base) begin
            chk("sw_ctrl", wr_log[base].c, 3'b010);
            chk("sw_addr", wr_log[base].a, 32'h10);
            chk("sw_data", wr_log[base].d, 32'hDEADBEEF);
        end
        xact(1'b0, 3'b010, 32'h10, 32'h0, r); chk("lw_10", r, 32'hDEADBEEF);
        xact(1'b0, 3'b000, 32'h13, 32'h0, r); chk("lb_13", r, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'h0, r); chk("lbu_13", r, 32'h000000DE);
        xact(1'b0, 3'b101, 32'h12, 32'h0, r); chk("lhu_12", r, 32'h0000DEAD);
        xact(1'b0, 3'b001, 32'h10, 32'h0, r); chk("lh_10", r, 32'hFFFFBEEF);

        base = wr_log.size();
        xact(1'b1, 3'b010, 32'h21, 32'h11223344, r);
        chk("ssw_nwrites", wr_log.size() - base, 4);
        if (wr_log.size() >= base + 4)
            for (int k = 0; k < 4; k++) begin
                chk("ssw_ctrl", wr_log[base + k].c, 3'b000);
                chk("ssw_addr", wr_log[base + k].a, 32'h21 + k);
                chk("ssw_data", wr_log[base + k].d, (32'h11223344 >> (8 * k)) & 32'hFF);
            end
        xact(1'b0, 3'b010, 32'h21, 32'h0, r); chk("slw_21", r, 32'h11223344);

        base = wr_log.size();
        xact(1'b1, 3'b001, 32'h05, 32'h80FF, r);
        chk("ssh_nwrites", wr_log.size() - base, 2);
        if (wr_log.size() >= base + 2) begin
            chk("ssh_b0", {wr_log[base].a[7:0], wr_log[base].d[23:0]}, 32'h050000FF);
            chk("ssh_b1", {wr_log[base + 1].a[7:0], wr_log[base + 1].d[23:0]}, 32'h06000080);
        end
        xact(1'b0, 3'b001, 32'h05, 32'h0, r); chk("slh_05", r, 32'hFFFF80FF);
        xact(1'b0, 3'b101, 32'h05, 32'h0, r); chk("slhu_05", r, 32'h000080FF);

        xact(1'b0, 3'b011, 32'h40, 32'h0, r); chk("ill_load_err", resp_err, 1'b0);
        xact(1'b1, 3'b100, 32'h40, 32'h5A5A5A5A, r);
        xact(1'b1, 3'b010, 32'hFFFFFFFF, 32'hCAFEF00D, r);
        xact(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, r); chk("wrap_lw", r, 32'hCAFEF00D);

        @(negedge clk);
        ns_req_valid = 1'b1;
        @(posedge clk);
        #1 ns_req_valid = 1'b0;
        @(negedge clk);
        chk("ns_resp_valid", ns_resp_valid, 1'b1);
        chk("ns_resp_err", ns_resp_err, 1'b1);
        chk("ns_rdata", ns_resp_rdata, 32'h0);
        @(negedge clk);
        chk("ns_ready", ns_req_ready, 1'b1);
        chk("ns_no_access", ns_acc_cnt, 0);

        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h31; req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_pre_ctrl", mem_write_ctrl, 3'b000);
        chk("mid_pre_addr", mem_addr, 32'h33);
        rst = 1'b1;
        #1;
        chk("mid_rd_ctrl", mem_read_ctrl, 3'b111);
        chk("mid_wr_ctrl", mem_write_ctrl, 3'b111);
        ref_mem[8'h31] = 8'hD4;
        ref_mem[8'h32] = 8'hC3;
        @(negedge clk);
        chk("mid_no_resp", resp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_no_resp2", resp_valid, 1'b0);
        chk("mid_ready", req_ready, 1'b1);
        for (int i = 8'h30; i <= 8'h35; i++) chk("mid_mem", mem[i], ref_mem[i]);

        for (int it = 0; it < 200; it++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'($urandom_range(0, 255));
            xact(st, f3, a, $urandom, r);
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
